// File: rtl/lane_render_pkg.sv
// Shared constants, lane decode helpers and FSM state type for the lane renderer.
package lane_render_pkg;

    localparam logic [2:0] LANE_EMPTY = 3'd0;
    localparam logic [2:0] LANE_A     = 3'd1;
    localparam logic [2:0] LANE_B     = 3'd2;
    localparam logic [2:0] LANE_C     = 3'd3;
    localparam logic [2:0] LANE_D     = 3'd4;

    localparam int         LANE_WIDTH = 20;
    localparam int         ROW_PITCH  = 40;
    localparam logic [5:0] OFFSET_MAX = 6'd39;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ERASE,
        DRAW,
        DONE
    } state_t;

    function automatic logic lane_valid(input logic [2:0] code);
        return (code >= LANE_A) && (code <= LANE_D);
    endfunction

    // Codes 5..7 fall through to the empty base, same as LANE_EMPTY.
    function automatic logic [8:0] lane_x_base(input logic [2:0] code);
        case (code)
            LANE_EMPTY: return 9'd0;
            LANE_A:     return 9'd120;
            LANE_B:     return 9'd140;
            LANE_C:     return 9'd160;
            LANE_D:     return 9'd180;
            default:    return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/lane_render_scheduler_span_writer.sv
// Walks x across one LANE_WIDTH-pixel span; done is high on the last pixel.
module span_writer
    import lane_render_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [8:0] base_x,
    output logic [8:0] x,
    output logic       done
);

    logic [4:0] remain;
    logic       active;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            remain <= '0;
            active <= 1'b0;
        end else if (start) begin
            x      <= base_x;
            remain <= 5'(LANE_WIDTH - 1);
            active <= 1'b1;
        end else if (active) begin
            if (remain == 5'd0) begin
                active <= 1'b0;
            end else begin
                remain <= remain - 5'd1;
                x      <= x + 9'd1;
            end
        end
    end

    assign done = active && (remain == 5'd0);

endmodule

// File: rtl/lane_render_scheduler.sv
// Per-frame row scheduler: for each lane row, erase the old span then draw it one line lower.
//  state | meaning
//  IDLE  | waiting for an enabled frame_tick
//  LOAD  | decode current row's snapshotted lane code (1 cycle)
//  ERASE | plot black span at row_y + offset
//  DRAW  | plot white span at row_y + offset_next
//  DONE  | frame_done pulse, advance scroll offset (1 cycle)
module lane_render_scheduler
    import lane_render_pkg::*;
#(
    parameter int NUM_ROWS  = 4,
    parameter int ROW_PITCH = lane_render_pkg::ROW_PITCH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  frame_tick,
    input  logic [3*NUM_ROWS-1:0] lane_code,
    output logic [8:0]            x_out,
    output logic [7:0]            y_out,
    output logic [2:0]            c_out,
    output logic                  plot,
    output logic                  busy,
    output logic                  frame_done,
    output logic [5:0]            offset,
    output logic                  wrap,
    output logic                  overrun
);

    state_t                state;
    logic [2:0]            row_idx;
    logic [3*NUM_ROWS-1:0] lane_q;
    logic [2:0]            cur_code;
    logic [5:0]            offset_next;
    logic [7:0]            row_y;
    logic                  last_row;
    logic                  span_start;
    logic                  span_done;
    logic [8:0]            span_x;

    always_comb begin
        cur_code = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_idx == 3'(r)) cur_code = lane_q[3*r +: 3];
        end
    end

    assign offset_next = (offset == OFFSET_MAX) ? 6'd0 : offset + 6'd1;
    assign row_y       = 8'(int'(row_idx) * ROW_PITCH);
    assign last_row    = (row_idx == 3'(NUM_ROWS - 1));
    assign span_start  = ((state == LOAD) && lane_valid(cur_code)) ||
                         ((state == ERASE) && span_done);

    span_writer u_span (
        .clk    (clk),
        .resetn (resetn),
        .start  (span_start),
        .base_x (lane_x_base(cur_code)),
        .x      (span_x),
        .done   (span_done)
    );

    assign x_out = plot ? span_x : 9'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            row_idx    <= '0;
            lane_q     <= '0;
            offset     <= '0;
            overrun    <= 1'b0;
            plot       <= 1'b0;
            y_out      <= '0;
            c_out      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            wrap       <= 1'b0;
            if (frame_tick && (state != IDLE)) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_tick && enable) begin
                        lane_q  <= lane_code;
                        row_idx <= '0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (lane_valid(cur_code)) begin
                        plot  <= 1'b1;
                        c_out <= BLACK;
                        y_out <= 8'(row_y + {2'b00, offset});
                        state <= ERASE;
                    end else if (last_row) begin
                        frame_done <= 1'b1;
                        wrap       <= (offset == OFFSET_MAX);
                        offset     <= offset_next;
                        state      <= DONE;
                    end else begin
                        row_idx <= row_idx + 3'd1;
                    end
                end
                ERASE: begin
                    if (span_done) begin
                        c_out <= WHITE;
                        y_out <= 8'(row_y + {2'b00, offset_next});
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (span_done) begin
                        plot  <= 1'b0;
                        c_out <= '0;
                        y_out <= '0;
                        if (last_row) begin
                            frame_done <= 1'b1;
                            wrap       <= (offset == OFFSET_MAX);
                            offset     <= offset_next;
                            state      <= DONE;
                        end else begin
                            row_idx <= row_idx + 3'd1;
                            state   <= LOAD;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
